fft64_frame_ctrl: RTL
=====================

# fft64_frame_ctrl

Frame sequencer for the 64-point FFT core. It accepts complex samples on a valid/ready stream, issues START, gates ED, and feeds DR/DI to the core. It then waits for RDY and returns the 64 results, with their ADDR index, on a valid/ready stream. It also tracks OVF1/OVF2 and can raise SHIFT automatically between frames (block-floating-point scaling). It sits in the core domain between the system interface and the FFT core's `_C` pins.

## Interface
- TIMEOUT_CYC, 512: maximum DRAIN cycles to wait for RDY before abort.
- CLK  in  1  sole clock.
- RST  in  1  reset. Asynchronous assertion, active-low.
- cfg_shift  in  4  SHIFT used when auto-scaling is off, or when the shift is reloaded.
- cfg_auto  in  1  enable auto-scaling.
- status_clr  in  1  one-cycle pulse. Clears ovf_sticky and timeout_err, and reloads the shift from cfg_shift.
- in_valid / in_ready  in / out  1  input handshake.
- in_re, in_im  in  16  input sample.
- out_valid / out_ready  out / in  1  output handshake.
- out_re, out_im  out  19  result.
- out_idx  out  6  result index, taken from fft_addr.
- out_last  out  1  high on the 64th result of a frame.
- fft_start  out  1  START to the core.
- fft_ed  out  1  ED to the core.
- fft_dr, fft_di  out  16  DR and DI to the core.
- fft_shift  out  4  SHIFT to the core.
- fft_rdy, fft_ovf1, fft_ovf2  in  1  from the core.
- fft_addr  in  6  from the core.
- fft_dor, fft_doi  in  19  from the core.
- busy  out  1  high whenever the state is not IDLE.
- ovf_sticky, timeout_err  out  1  sticky status bits.
- frame_cnt  out  16  completed frames. Wraps.

## Operation
Core contract: the core's outputs change only on edges where ED=1. Result k=0 is present from the edge on which RDY rises. Each later ED edge advances the output to k+1.

States and transitions:
- IDLE
  - in_ready=0, fft_ed=0.
  - Go to START when in_valid=1.
- START
  - fft_start=1 for exactly one cycle, fft_ed=0.
  - shift_reg is loaded from cfg_shift if cfg_auto=0, or if this is the first frame since reset or status_clr.
  - Clear sample_cnt and frame_ovf.
  - Go to LOAD.
- LOAD
  - in_ready=1, fft_ed=in_valid.
  - fft_dr/fft_di = in_re/in_im, combinational.
  - Each handshake increments sample_cnt. The handshake at sample_cnt=63 moves the state to DRAIN.
- DRAIN
  - fft_ed=~fft_rdy.
  - Go to UNLOAD when fft_rdy=1. Result 0 is held on the core's outputs.
  - wait_cnt counts DRAIN cycles. When it reaches TIMEOUT_CYC: set timeout_err, go to IDLE, and leave frame_cnt unchanged.
- UNLOAD
  - out_valid=1, fft_ed=out_ready.
  - out_re/out_im/out_idx = fft_dor/fft_doi/fft_addr.
  - out_last = (out_cnt==63).
  - The handshake at out_cnt=63 ends the frame. Go to START if in_valid=1, otherwise IDLE.

Overflow and scaling:
- frame_ovf |= fft_ovf1|fft_ovf2 on every cycle in DRAIN or UNLOAD where fft_ed=1.
- At frame end:
  - ovf_sticky |= frame_ovf.
  - frame_cnt increments.
  - If cfg_auto=1 and frame_ovf=1, shift_reg increments, saturating at 15.
- fft_shift = shift_reg. It is stable from START until frame end.
- When fft_dr/fft_di are outside LOAD: drive 0.
- When out_* are outside UNLOAD: drive 0.

## Timing
- Reset values: every output is 0, including shift_reg, frame_cnt and the status bits. State is IDLE.
- Mid-frame reset: the block returns immediately to IDLE with all outputs 0. No partial output follows.
- Entry latency: in_valid in IDLE → START on the next cycle → in_ready on the cycle after that. The first sample is accepted two cycles after in_valid.
- Back-to-back frames: the last output handshake is followed by one START cycle, then LOAD.
- Stalls:
  - in_valid=0 during LOAD freezes the core (fft_ed=0). sample_cnt holds.
  - out_ready=0 during UNLOAD holds the same result with out_valid=1.
- status_clr:
  - Coincides with a frame end: the clear wins for ovf_sticky, but frame_cnt still increments.
  - Mid-frame: the shift reload takes effect at the next START.
- wait_cnt: width $clog2(TIMEOUT_CYC+1). Resets on DRAIN entry.

## Structure
- Package fft64_ctrl_pkg contains:
  - the state enum (IDLE, START, LOAD, DRAIN, UNLOAD);
  - N_PTS=64, IN_W=16, OUT_W=19, SHIFT_W=4, SHIFT_MAX=15.
- Sub-module fft64_shift_adapt holds shift_reg, the first-frame flag, and the saturating increment. Its inputs are frame_start, frame_end, frame_ovf, cfg_auto, cfg_shift and status_clr.
- The top level holds the FSM, the counters and the muxing.

## Test plan
- Basic frame: cfg_auto=0, cfg_shift=3. Send 64 samples with no stalls. Behavioural core model with RDY 140 cycles after the last ED.
  - Expect: fft_start exactly one cycle; 64 ED pulses in LOAD; fft_shift=3 throughout.
  - Expect: 64 outputs with out_idx 0..63 and out_last only on idx 63; frame_cnt=1.
- Backpressure: random in_valid and out_ready gaps.
  - Expect: fft_ed tracks the handshakes exactly; no result duplicated or lost; data matches the model.
- Auto-scaling: cfg_auto=1, cfg_shift=14. The model raises OVF1 in frames 1 and 2.
  - Expect: fft_shift is 14, then 15, then 15 (saturated); ovf_sticky=1.
  - Then pulse status_clr. Expect ovf_sticky=0, and the next frame uses fft_shift=14.
- Timeout: the model never asserts RDY and TIMEOUT_CYC=512.
  - Expect: after 512 DRAIN cycles, timeout_err=1, state IDLE, frame_cnt unchanged.
  - Expect: the next frame runs normally.
- Reset mid-UNLOAD at result 20.
  - Expect: all outputs 0 asynchronously, busy=0.
  - Expect: after release, a new frame completes with 64 results.

Source files
------------

// File: rtl/fft64_ctrl_pkg.sv
// Shared types and constants for the 64-point FFT frame sequencer.
// Imported by the top level and the shift adaptation block.
package fft64_ctrl_pkg;

  localparam int N_PTS   = 64;
  localparam int IN_W    = 16;
  localparam int OUT_W   = 19;
  localparam int SHIFT_W = 4;
  localparam logic [SHIFT_W-1:0] SHIFT_MAX = 4'd15;

  typedef enum logic [2:0] {
    IDLE,
    START,
    LOAD,
    DRAIN,
    UNLOAD
  } state_t;

  function automatic logic [SHIFT_W-1:0] sat_inc(
    input logic [SHIFT_W-1:0] v
  );
    return (v == SHIFT_MAX) ? v : v + SHIFT_W'(1);
  endfunction

endpackage

// File: rtl/fft64_shift_adapt.sv
// Block-floating-point SHIFT tracking for the FFT core.
// Reloads from cfg on the first frame after reset/clear or when auto is off.
module fft64_shift_adapt
  import fft64_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_start,
  input  logic               frame_end,
  input  logic               frame_ovf,
  input  logic               cfg_auto,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               status_clr,
  output logic [SHIFT_W-1:0] shift
);

  logic first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
      first <= 1'b1;
    end else begin
      if (status_clr) begin
        first <= 1'b1;
      end else if (frame_start) begin
        first <= 1'b0;
      end
      if (frame_start && (!cfg_auto || first || status_clr)) begin
        shift <= cfg_shift;
      end else if (frame_end && cfg_auto && frame_ovf) begin
        shift <= sat_inc(shift);
      end
    end
  end

endmodule

// File: rtl/fft64_frame_ctrl.sv
// Frame sequencer for the 64-point FFT core: load, drain, unload,
// overflow tracking and automatic SHIFT scaling between frames.
module fft64_frame_ctrl
  import fft64_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 512
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               cfg_auto,
  input  logic               status_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_re,
  input  logic [IN_W-1:0]    in_im,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   out_re,
  output logic [OUT_W-1:0]   out_im,
  output logic [5:0]         out_idx,
  output logic               out_last,
  output logic               fft_start,
  output logic               fft_ed,
  output logic [IN_W-1:0]    fft_dr,
  output logic [IN_W-1:0]    fft_di,
  output logic [SHIFT_W-1:0] fft_shift,
  input  logic               fft_rdy,
  input  logic               fft_ovf1,
  input  logic               fft_ovf2,
  input  logic [5:0]         fft_addr,
  input  logic [OUT_W-1:0]   fft_dor,
  input  logic [OUT_W-1:0]   fft_doi,
  output logic               busy,
  output logic               ovf_sticky,
  output logic               timeout_err,
  output logic [15:0]        frame_cnt
);

  localparam int WC_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [5:0] LAST_IDX = 6'(N_PTS - 1);

  state_t state, state_nx;
  logic [5:0] sample_cnt;
  logic [5:0] out_cnt;
  logic [WC_W-1:0] wait_cnt;
  logic frame_ovf;
  logic in_hs, out_hs, frame_end, timeout;
  logic ovf_hit, ovf_nx;

  assign in_hs     = (state == LOAD) && in_valid;
  assign out_hs    = (state == UNLOAD) && out_ready;
  assign frame_end = out_hs && (out_cnt == LAST_IDX);
  assign timeout   = (state == DRAIN) && !fft_rdy
                  && (wait_cnt == WC_W'(TIMEOUT_CYC - 1));
  assign ovf_hit   = ((state == DRAIN) || (state == UNLOAD))
                  && fft_ed && (fft_ovf1 || fft_ovf2);
  assign ovf_nx    = frame_ovf || ovf_hit;

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    fft_start = 1'b0;
    fft_ed    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nx = START;
      end
      START: begin
        fft_start = 1'b1;
        state_nx  = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        fft_ed   = in_valid;
        if (in_valid && (sample_cnt == LAST_IDX)) state_nx = DRAIN;
      end
      DRAIN: begin
        fft_ed = ~fft_rdy;
        if (fft_rdy) state_nx = UNLOAD;
        else if (timeout) state_nx = IDLE;
      end
      UNLOAD: begin
        out_valid = 1'b1;
        fft_ed    = out_ready;
        if (frame_end) state_nx = in_valid ? START : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy     = (state != IDLE);
  assign fft_dr   = in_ready ? in_re : '0;
  assign fft_di   = in_ready ? in_im : '0;
  assign out_re   = out_valid ? fft_dor : '0;
  assign out_im   = out_valid ? fft_doi : '0;
  assign out_idx  = out_valid ? fft_addr : '0;
  assign out_last = out_valid && (out_cnt == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      out_cnt     <= '0;
      wait_cnt    <= '0;
      frame_ovf   <= 1'b0;
      ovf_sticky  <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == START) begin
        sample_cnt <= '0;
        out_cnt    <= '0;
        frame_ovf  <= 1'b0;
      end else begin
        if (in_hs) sample_cnt <= sample_cnt + 6'd1;
        if (out_hs) out_cnt <= out_cnt + 6'd1;
        if (ovf_hit) frame_ovf <= 1'b1;
      end
      if (state == LOAD) wait_cnt <= '0;
      else if (state == DRAIN) wait_cnt <= wait_cnt + WC_W'(1);
      // A clear on the frame-end cycle wins over the overflow merge
      if (status_clr) ovf_sticky <= 1'b0;
      else if (frame_end) ovf_sticky <= ovf_sticky || ovf_nx;
      if (status_clr) timeout_err <= 1'b0;
      else if (timeout) timeout_err <= 1'b1;
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  fft64_shift_adapt u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (state == START),
    .frame_end   (frame_end),
    .frame_ovf   (ovf_nx),
    .cfg_auto    (cfg_auto),
    .cfg_shift   (cfg_shift),
    .status_clr  (status_clr),
    .shift       (fft_shift)
  );

endmodule
